// File: rtl/avg_frame_serializer.sv
// avg_frame_serializer
//   Buffers 6-bit averaged samples {t[1:0], y[1:0], x[1:0]} in a small FIFO.
//   Sends each sample on one pin as a UART-style frame: start (0), DATA_W data
//   bits LSB first, even parity, stop (1).
//
// Ports
//   clk          : clock, all logic on the rising edge
//   rst_n        : synchronous reset, ACTIVE-HIGH (1 resets; name is historical)
//   sample_in    : averaged sample, [1:0]=x, [3:2]=y, [5:4]=t
//   sample_valid : sample_in is valid this cycle (upstream cannot stall)
//   sample_ready : FIFO has room this cycle (combinational from the count)
//   clr_ovf      : clears the sticky overflow flag
//   tx           : registered serial output, idles high
//   busy         : registered, high while a frame is on the wire
//   fifo_count   : number of buffered samples, 0..FIFO_DEPTH
//   overflow     : sticky, a valid sample was dropped because the FIFO was full
module avg_frame_serializer #(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH   = 4,
   parameter int DATA_W       = 6
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_W-1:0]             sample_in,
   input  logic                          sample_valid,
   output logic                          sample_ready,
   input  logic                          clr_ovf,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int BC_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = $clog2(DATA_W);

   localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // Even parity bit: makes the total count of ones in data+parity even.
   function automatic logic even_parity(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction

   // FIFO storage and bookkeeping
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              ready_s, push_s, drop_s, pop_s;
   logic [DATA_W-1:0] head_s;

   // Transmit FSM
   state_t            state_q, state_d;
   logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;

   // Ready never anticipates a same-edge pop: a full FIFO refuses the push.
   assign ready_s      = (count_q < CNT_FULL);
   assign head_s       = mem_q[rd_ptr_q];

   assign sample_ready = ready_s;
   assign tx           = tx_q;
   assign busy         = busy_q;
   assign fifo_count   = count_q;
   assign overflow     = ovf_q;

   // FIFO pointer/count next-state and sticky overflow (a new drop beats clear)
   always_comb begin
      push_s   = sample_valid & ready_s;
      drop_s   = sample_valid & ~ready_s;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (drop_s) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Frame sequencer: tx_d is the value the pin takes after this edge
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      par_d     = par_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      pop_s     = 1'b0;
      case (state_q)
         S_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (count_q != CNT_W'(0)) begin
               pop_s     = 1'b1;
               shift_d   = head_s;
               par_d     = even_parity(head_s);
               bit_cnt_d = BC_W'(0);
               tx_d      = 1'b0;
               busy_d    = 1'b1;
               state_d   = S_START;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_START: begin
            if (bit_cnt_q == BIT_LAST) begin
               bit_cnt_d = BC_W'(0);
               idx_d     = IDX_W'(0);
               tx_d      = shift_q[0];
               state_d   = S_DATA;
            end else begin
               bit_cnt_d = bit_cnt_q + BC_W'(1);
               tx_d      = 1'b0;
            end
         end
         S_DATA: begin
            if (bit_cnt_q == BIT_LAST) begin
               bit_cnt_d = BC_W'(0);
               if (idx_q == IDX_LAST) begin
                  tx_d    = par_q;
                  state_d = S_PARITY;
               end else begin
                  // Next bit is shift_q[1], which becomes shift[0] after the shift
                  idx_d   = idx_q + IDX_W'(1);
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end else begin
               bit_cnt_d = bit_cnt_q + BC_W'(1);
               tx_d      = shift_q[0];
            end
         end
         S_PARITY: begin
            if (bit_cnt_q == BIT_LAST) begin
               bit_cnt_d = BC_W'(0);
               tx_d      = 1'b1;
               state_d   = S_STOP;
            end else begin
               bit_cnt_d = bit_cnt_q + BC_W'(1);
               tx_d      = par_q;
            end
         end
         S_STOP: begin
            tx_d = 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
               bit_cnt_d = BC_W'(0);
               busy_d    = 1'b0;
               state_d   = S_IDLE;
            end else begin
               bit_cnt_d = bit_cnt_q + BC_W'(1);
            end
         end
         default: begin
            tx_d      = 1'b1;
            busy_d    = 1'b0;
            bit_cnt_d = BC_W'(0);
            state_d   = S_IDLE;
         end
      endcase
   end

   // FIFO storage write (contents need no reset; pointers gate visibility)
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= sample_in;
      end
   end

   // State registers; reset aborts any frame and discards buffered samples
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= BC_W'(0);
         idx_q     <= IDX_W'(0);
         shift_q   <= DATA_W'(0);
         par_q     <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         wr_ptr_q  <= PTR_W'(0);
         rd_ptr_q  <= PTR_W'(0);
         count_q   <= CNT_W'(0);
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
      end
   end

endmodule

// File: doc/avg_frame_serializer.md
Name: avg_frame_serializer

Overview:
Downstream stage of the x/y/t moving-average block. Takes each 6-bit averaged sample {t[1:0], y[1:0], x[1:0]} and buffers it in a small FIFO. Transmits each sample on a single output pin as a UART-style frame: start, 6 data bits LSB first, even parity, stop. Drives a spare output pin so smoothed data can leave the chip serially.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit; integer >= 1
FIFO_DEPTH, 4, sample buffer entries; power of two, >= 2
DATA_W, 6, sample width; fixed at 6 (x, y, t, 2 bits each)

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  reset, synchronous, active-high (asserted = 1 resets the block; name kept per codebase convention)
sample_in  input  6  averaged sample; [1:0]=x, [3:2]=y, [5:4]=t
sample_valid  input  1  sample_in is valid this cycle
sample_ready  output  1  FIFO can accept a sample this cycle
clr_ovf  input  1  clears the overflow flag
tx  output  1  serial output; idles high
busy  output  1  a frame is being transmitted
fifo_count  output  3  samples currently buffered (0..FIFO_DEPTH)
overflow  output  1  sticky: a valid sample was dropped

Behaviour:
- Reset (rst_n=1 at an edge): tx=1, busy=0, fifo_count=0, overflow=0, state=IDLE, FIFO pointers=0. sample_ready=1 in the cycle after reset.
- Reset mid-frame aborts the frame. tx returns high on the reset edge and buffered samples are discarded.
- sample_ready is combinational and equals (fifo_count < FIFO_DEPTH). It does not look ahead to a same-cycle pop: when the FIFO is full, a push is refused even if a pop happens on the same edge.
- Push occurs on an edge with sample_valid=1 and sample_ready=1.
- Upstream cannot stall. If sample_valid=1 and sample_ready=0, the sample is dropped and overflow is set on that edge.
- overflow stays set until an edge with clr_ovf=1. If clr_ovf and a new drop occur on the same edge, the set wins.
- FIFO order is strictly first-in first-out. Push and pop on the same edge leave fifo_count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP. A bit counter runs 0..CLKS_PER_BIT-1 and a data index runs 0..5.
- IDLE: tx=1. On an edge with fifo_count>0:
  - pop the head entry into the shift register;
  - latch parity = XOR of its 6 bits;
  - set tx=0 and move to START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx = shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit. After 6 bits, move to PARITY.
- PARITY: tx = latched parity for CLKS_PER_BIT cycles, then STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- A frame is 9*CLKS_PER_BIT cycles.
- IDLE always lasts at least one cycle, so back-to-back frames are separated by exactly one extra high cycle.
- Latency: a sample pushed at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. tx is low from N+1.
- tx and busy are registered. busy=1 in every state except IDLE.
- fifo_count is 3 bits for the default depth. Width is clog2(FIFO_DEPTH)+1 in general.

Test Plan:
- Reset, then push sample_in=6'h27 once with CLKS_PER_BIT=4 -> tx low one edge after the push. Bits, 4 cycles each: 0,1,1,1,0,0,1,0(parity),1. Then tx=1 and busy=0 after 36 cycles.
- Six consecutive valid cycles A..F, FIFO empty, FSM in IDLE -> A is popped on the second edge and B..E fill the FIFO (fifo_count=4). F is dropped: sample_ready=0 and overflow=1. Frames A,B,C,D,E follow in order, each separated by one idle-high cycle.
- overflow set, then clr_ovf=1 for one cycle -> overflow=0. Repeat with clr_ovf=1 and a drop on the same edge -> overflow stays 1.
- Assert rst_n during the DATA state of a frame with 2 samples buffered -> next cycle: tx=1, busy=0, fifo_count=0. No further frames.
- CLKS_PER_BIT=1, sample 6'h3F -> 9-cycle frame 0,1,1,1,1,1,1,0,1 (even parity of six ones = 0).
- Sample 6'h01 -> parity bit=1. Full frame: 0,1,0,0,0,0,0,1,1.
